// File: rtl/ucsbece154b_bp_pkg.sv
// Shared definitions for the second-generation branch predictor:
// control-flow type encodings, PHT reset value and the 2-bit counter step.
package ucsbece154b_bp_pkg;

  typedef enum logic [1:0] {
    BT_COND = 2'b00,
    BT_JUMP = 2'b01,
    BT_CALL = 2'b10,
    BT_RET  = 2'b11
  } bp_type_e;

  localparam logic [1:0] PHT_RESET = 2'b01;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'd1;
    if (!taken && ctr != 2'b00) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; popping when empty is ignored. top_o is the most recent push.
module ucsbece154b_ras #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              push_data_i,
  output logic [31:0]              top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   entry_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] top_idx;

  // ptr_q points at the next free slot; the top lives one below it.
  assign top_idx = ptr_q - PW'(1);
  assign top_o   = entry_q[top_idx];
  assign count_o = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end else if (pop_i && count_q != '0) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push_i) entry_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch_predictor_gen2.sv
// Parametrised BTB + PHT (bimodal or gshare) + RAS predictor, looked up
// combinationally at fetch and trained non-speculatively from Execute.
module ucsbece154b_branch_predictor_gen2
  import ucsbece154b_bp_pkg::*;
#(
  parameter int BTB_IDX_BITS = 4,
  parameter int GHR_BITS     = 6,
  parameter bit MODE_GSHARE  = 1'b1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [31:0]         pc_f_i,
  input  logic                stall_f_i,
  output logic                pred_taken_f_o,
  output logic [31:0]         pred_target_f_o,
  output logic [GHR_BITS-1:0] ghr_f_o,
  input  logic                upd_valid_e_i,
  input  logic [31:0]         upd_pc_e_i,
  input  logic [31:0]         upd_target_e_i,
  input  logic                upd_taken_e_i,
  input  logic [1:0]          upd_type_e_i,
  input  logic [GHR_BITS-1:0] upd_ghr_e_i,
  input  logic                mispredict_e_i
);

  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = 30 - BTB_IDX_BITS;
  localparam int PHT_N = 1 << GHR_BITS;

  logic              btb_valid_q [BTB_N];
  logic [TAG_W-1:0]  btb_tag_q   [BTB_N];
  logic [31:0]       btb_tgt_q   [BTB_N];
  bp_type_e          btb_type_q  [BTB_N];
  logic [1:0]        pht_q       [PHT_N];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic [31:0]            ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;

  logic [BTB_IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]        f_tag, u_tag;
  logic [GHR_BITS-1:0]     f_pht_idx, u_pht_idx;
  logic                    f_hit;
  bp_type_e                f_type, u_type;
  logic                    pred_taken;
  logic [31:0]             pred_tgt;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{pc_f_i[1:0], upd_pc_e_i[1:0]};

  assign f_idx     = pc_f_i[BTB_IDX_BITS+1:2];
  assign f_tag     = pc_f_i[31:BTB_IDX_BITS+2];
  assign f_hit     = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_type    = btb_type_q[f_idx];
  assign f_pht_idx = pc_f_i[GHR_BITS+1:2] ^ (MODE_GSHARE ? ghr_q : '0);

  assign u_idx     = upd_pc_e_i[BTB_IDX_BITS+1:2];
  assign u_tag     = upd_pc_e_i[31:BTB_IDX_BITS+2];
  assign u_type    = bp_type_e'(upd_type_e_i);
  assign u_pht_idx = upd_pc_e_i[GHR_BITS+1:2] ^ (MODE_GSHARE ? upd_ghr_e_i : '0);

  always_comb begin
    pred_taken = 1'b0;
    pred_tgt   = '0;
    if (f_hit) begin
      case (f_type)
        BT_COND: begin
          pred_taken = pht_q[f_pht_idx][1];
          pred_tgt   = btb_tgt_q[f_idx];
        end
        BT_JUMP, BT_CALL: begin
          pred_taken = 1'b1;
          pred_tgt   = btb_tgt_q[f_idx];
        end
        BT_RET: begin
          pred_taken = (ras_count != '0);
          pred_tgt   = ras_top;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low during reset so state left over from before
  // the reset (or uninitialised at power-up) never reaches fetch.
  assign pred_taken_f_o  = !reset_i && pred_taken;
  assign pred_target_f_o = reset_i ? '0 : pred_tgt;
  assign ghr_f_o         = reset_i ? '0 : ghr_q;

  // Checkpoint repair wins over the speculative shift of a younger fetch.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_e_i && mispredict_e_i) begin
      ghr_d = (u_type == BT_COND) ? {upd_ghr_e_i[GHR_BITS-2:0], upd_taken_e_i}
                                  : upd_ghr_e_i;
    end else if (f_hit && f_type == BT_COND && !stall_f_i && !mispredict_e_i) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_N; i++) btb_valid_q[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_RESET;
    end else begin
      ghr_q <= ghr_d;
      if (upd_valid_e_i && u_type == BT_COND)
        pht_q[u_pht_idx] <= sat_update(pht_q[u_pht_idx], upd_taken_e_i);
      if (upd_valid_e_i && upd_taken_e_i)
        btb_valid_q[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i && upd_valid_e_i && upd_taken_e_i) begin
      btb_tag_q[u_idx]  <= u_tag;
      btb_tgt_q[u_idx]  <= upd_target_e_i;
      btb_type_q[u_idx] <= u_type;
    end
  end

  ucsbece154b_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .reset_i     (reset_i),
    .push_i      (upd_valid_e_i && u_type == BT_CALL),
    .pop_i       (upd_valid_e_i && u_type == BT_RET),
    .push_data_i (upd_pc_e_i + 32'd4),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

endmodule
